keypad_driver: RTL and testbench
================================

// Module: keypad_driver
// PURPOSE
//   Input-side counterpart of the digital-tube output driver: scans a 4x4 matrix keypad,
//   debounces, and turns each press into a 4-bit hex code. Codes shift into a 32-bit
//   number (8 hex digits) that the CPU reads through the IO bus. key_valid flags a new
//   digit; an IORead strobe acknowledges it.
// PARAMETERS
//   SCAN_DIV        40000  clock cycles per row dwell; one scan tick per dwell
//   DEBOUNCE_TICKS  4      consecutive matching ticks required for press and for release
// PORTS
//   clock          in   1   system clock
//   rst            in   1   reset, asynchronous, active-low
//   iKeypadCol     in   4   column sense, active-low, asynchronous to clock
//   oKeypadRow     out  4   row drive, active-low, one-hot-zero
//   IORead         in   1   1-cycle strobe: CPU read of out_num; clears key_valid and key_overrun
//   iClearNum      in   1   synchronous clear of out_num and key_valid
//   key_code       out  4   last committed key, {row_idx[1:0], col_idx[1:0]}
//   key_valid      out  1   sticky: new key committed since last IORead
//   key_overrun    out  1   sticky: commit happened while key_valid was already 1
//   out_num        out  32  entered number; newest digit in [3:0]
// BEHAVIOUR
//   Reset: oKeypadRow=4'b1110, row_idx=0, key_code=0, key_valid=0, key_overrun=0,
//     out_num=0, state=SCAN, tick counter=0, debounce counter=0.
//   iKeypadCol passes through a 2-flop synchroniser; every decision uses the synced value.
//   Tick: divider counts 0..SCAN_DIV-1; tick is high in the cycle where count==SCAN_DIV-1.
//   Columns are sampled only on a tick. "Single" means exactly one synced column is low.
//   FSM states:
//     SCAN     On a tick with all cols high or more than one low: row_idx+1 (3 wraps to 0).
//              On a tick with a single col: latch cand={row_idx,col}, cnt=1, go DEBOUNCE.
//              The row is frozen from here until the FSM returns to SCAN.
//     DEBOUNCE On a tick where the col pattern equals cand: cnt+1. When cnt reaches
//              DEBOUNCE_TICKS, commit and go HELD. On a tick with any other pattern:
//              cnt=0, row_idx+1, go SCAN.
//     HELD     On a tick with all cols high: cnt=1, go RELEASE. Otherwise stay;
//              auto-repeat is never generated.
//     RELEASE  On a tick with all cols high: cnt+1. When cnt reaches DEBOUNCE_TICKS:
//              row_idx+1, go SCAN. On a tick with any col low: go HELD.
//   Commit: key_code<=cand, out_num<={out_num[27:0],cand}, key_valid<=1.
//     key_overrun<=1 if key_valid was already 1. Outputs update the cycle after the tick.
//     The oldest digit in out_num[31:28] is discarded.
//   Latency: the first low sample counts as 1, so the commit lands on the
//     DEBOUNCE_TICKS-th consecutive matching tick.
//   Simultaneous events, by priority:
//     IORead and commit in the same cycle: the commit wins; key_valid stays 1 and
//       key_overrun is cleared.
//     iClearNum and commit in the same cycle: the clear wins; out_num=0, key_valid=0.
//     iClearNum does not disturb the FSM, row_idx or key_code.
//   Reset asserted mid-scan: every register returns to its reset value at once;
//     a partial debounce is lost.
//   oKeypadRow is always the inverse of one-hot(row_idx), registered.
// STRUCTURE
//   keypad_pkg: FSM state encoding (SCAN, DEBOUNCE, HELD, RELEASE), KEY_W=4, NUM_W=32.
//   Sub-module keypad_scan_tick: SCAN_DIV divider producing the 1-cycle tick.
//     It uses the same async active-low rst.
//   Top-level contents: synchroniser, FSM, row counter, out_num shift register, flag logic.
// TESTING  (SCAN_DIV=4, DEBOUNCE_TICKS=3; model the keypad as a row/col switch matrix)
//   1 Press row2/col1, steady -> after 3 ticks: key_code=4'h9, out_num=32'h00000009,
//     key_valid=1. Pulse IORead -> key_valid=0.
//   2 Bounce: col low for 1 tick, then high, then low for 1 tick -> no commit;
//     the row resumes advancing.
//   3 Nine presses of 1,2,...,8,then A -> out_num=32'h2345678A; each press is released
//     before the next.
//   4 Hold a key for 50 ticks, release, press again -> exactly 2 commits.
//     A release glitch shorter than 3 ticks -> still only 1 commit for that hold.
//   5 Two commits without IORead -> key_overrun=1. IORead in the same cycle as a commit
//     -> key_valid=1 and key_overrun=0.
//   6 Two cols low in the same row -> ignored. Assert rst during DEBOUNCE -> all outputs
//     at reset values; oKeypadRow=4'b1110.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad driver.
// Latency: n/a (package).
// Backpressure: n/a (package).
package keypad_pkg;

   localparam int KEY_W = 4;   // {row_idx[1:0], col_idx[1:0]}
   localparam int NUM_W = 32;  // eight hex digits

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } kp_state_e;

   // True when exactly one column line is pulled low.
   function automatic logic col_single(input logic [3:0] col);
      logic [3:0] low;
      low = ~col;
      return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
   endfunction

   // Index of the low column; only meaningful when col_single() holds.
   function automatic logic [1:0] col_index(input logic [3:0] col);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!col[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Row-dwell divider: emits a 1-cycle tick once every SCAN_DIV clocks.
// Latency: tick is high in the cycle where the count equals SCAN_DIV-1.
// Backpressure: none; free-running.
// Ports: clock, rst (async active-low), tick (out).
module keypad_scan_tick #(
   parameter int SCAN_DIV = 40000
) (
   input  logic clock,
   input  logic rst,
   output logic tick
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      tick    = (count_q == LAST);
      count_d = tick ? '0 : count_q + CNT_W'(1);
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) count_q <= '0;
      else      count_q <= count_d;
   end

endmodule

// File: rtl/keypad_driver.sv
// 4x4 keypad scanner/debouncer shifting hex key codes into a 32-bit number.
// Latency: commit lands the cycle after the DEBOUNCE_TICKS-th matching scan tick.
// Backpressure: none; a commit while key_valid is set raises sticky key_overrun.
// Ports: clock, rst (async active-low), iKeypadCol (async, active-low),
//        oKeypadRow (active-low one-hot), IORead, iClearNum, key_code,
//        key_valid, key_overrun, out_num.
module keypad_driver
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 40000,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [3:0]       iKeypadCol,
   output logic [3:0]       oKeypadRow,
   input  logic             IORead,
   input  logic             iClearNum,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_overrun,
   output logic [NUM_W-1:0] out_num
);

   localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS);

   logic             tick;
   logic [3:0]       col_s1_q, col_s1_d, col_s2_q, col_s2_d;
   kp_state_e        state_q, state_d;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [3:0]       row_q, row_d;
   logic [KEY_W-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [KEY_W-1:0] key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             key_overrun_q, key_overrun_d;
   logic [NUM_W-1:0] out_num_q, out_num_d;

   logic [3:0]       col_sync;
   logic             all_high;
   logic             commit;

   keypad_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clock (clock),
      .rst   (rst),
      .tick  (tick)
   );

   always_comb begin
      col_s1_d = iKeypadCol;
      col_s2_d = col_s1_q;
      col_sync = col_s2_q;
      all_high = &col_sync;

      state_d   = state_q;
      row_idx_d = row_idx_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      commit    = 1'b0;

      // Row is only advanced from SCAN or on leaving DEBOUNCE/RELEASE, so it
      // stays on the pressed key's row for the whole press/hold/release.
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (col_single(col_sync)) begin
                  cand_d  = {row_idx_q, col_index(col_sync)};
                  cnt_d   = CNT_W'(1);
                  state_d = DEBOUNCE;
               end else begin
                  row_idx_d = row_idx_q + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (col_sync == ~(4'b0001 << cand_q[1:0])) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_d == DEB_LAST) begin
                     commit  = 1'b1;
                     state_d = HELD;
                  end
               end else begin
                  cnt_d     = '0;
                  row_idx_d = row_idx_q + 2'd1;
                  state_d   = SCAN;
               end
            end
            HELD: begin
               // No auto-repeat: a held key just waits here for release.
               if (all_high) begin
                  cnt_d   = CNT_W'(1);
                  state_d = RELEASE;
               end
            end
            RELEASE: begin
               if (all_high) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_d == DEB_LAST) begin
                     cnt_d     = '0;
                     row_idx_d = row_idx_q + 2'd1;
                     state_d   = SCAN;
                  end
               end else begin
                  state_d = HELD;
               end
            end
            default: state_d = SCAN;
         endcase
      end

      row_d = ~(4'b0001 << row_idx_d);

      // Flag priority: IORead clears, a commit overrides it, iClearNum overrides both.
      key_code_d    = commit ? cand_q : key_code_q;
      out_num_d     = out_num_q;
      key_valid_d   = key_valid_q;
      key_overrun_d = key_overrun_q;
      if (IORead) begin
         key_valid_d   = 1'b0;
         key_overrun_d = 1'b0;
      end
      if (commit) begin
         out_num_d   = {out_num_q[NUM_W-KEY_W-1:0], cand_q};
         key_valid_d = 1'b1;
         if (key_valid_q && !IORead) key_overrun_d = 1'b1;
      end
      if (iClearNum) begin
         out_num_d   = '0;
         key_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         col_s1_q      <= 4'hF;
         col_s2_q      <= 4'hF;
         state_q       <= SCAN;
         row_idx_q     <= 2'd0;
         row_q         <= 4'b1110;
         cand_q        <= '0;
         cnt_q         <= '0;
         key_code_q    <= '0;
         key_valid_q   <= 1'b0;
         key_overrun_q <= 1'b0;
         out_num_q     <= '0;
      end else begin
         col_s1_q      <= col_s1_d;
         col_s2_q      <= col_s2_d;
         state_q       <= state_d;
         row_idx_q     <= row_idx_d;
         row_q         <= row_d;
         cand_q        <= cand_d;
         cnt_q         <= cnt_d;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
         key_overrun_q <= key_overrun_d;
         out_num_q     <= out_num_d;
      end
   end

   assign oKeypadRow  = row_q;
   assign key_code    = key_code_q;
   assign key_valid   = key_valid_q;
   assign key_overrun = key_overrun_q;
   assign out_num     = out_num_q;

endmodule

// File: tb/tb_keypad_driver.sv
// Bench for keypad_driver: switch-matrix keypad model, scoreboard of expected commits.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_keypad_driver;
   import keypad_pkg::*;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;

   typedef struct packed {
      logic [3:0]  code;
      logic [31:0] num;
      logic        vld;
      logic        ovr;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst   = 1'b0;
   logic [3:0]  col;
   logic [3:0]  row;
   logic        io_read = 1'b0;
   logic        clr     = 1'b0;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_overrun;
   logic [31:0] out_num;

   logic [15:0] pressed = '0;   // bit {row,col} closes that switch
   exp_t        q[$];
   exp_t        e;
   logic [31:0] prev_num = '0;
   logic [31:0] exp_num  = '0;
   logic        exp_vld  = 1'b0;
   logic        exp_ovr  = 1'b0;
   int          n_cmp    = 0;
   int          n_fail   = 0;

   always #5 clock = ~clock;

   keypad_driver #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DEB)) dut (
      .clock       (clock),
      .rst         (rst),
      .iKeypadCol  (col),
      .oKeypadRow  (row),
      .IORead      (io_read),
      .iClearNum   (clr),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_overrun (key_overrun),
      .out_num     (out_num)
   );

   // A column reads low when any closed switch on it sits on a driven (low) row.
   always_comb begin
      col = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // Monitor: any change of out_num to a nonzero value is a commit.
   always @(negedge clock) begin
      if (!rst) begin
         prev_num = '0;
      end else if (out_num !== prev_num) begin
         if (out_num != 32'd0) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_commit: got out_num %h, want no commit", out_num);
            end else begin
               e = q.pop_front();
               check("sb_code", {28'd0, key_code}, {28'd0, e.code});
               check("sb_num", out_num, e.num);
               check("sb_valid", {31'd0, key_valid}, {31'd0, e.vld});
               check("sb_overrun", {31'd0, key_overrun}, {31'd0, e.ovr});
            end
         end
         prev_num = out_num;
      end
   end

   task automatic wait_row(input logic [1:0] r, input bit want_eq, input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if ((row == ~(4'b0001 << r)) == want_eq) begin
            ok = 1'b1;
            break;
         end
      end
      check(nm, {31'd0, ok}, 32'd1);
   endtask

   // Press key k; the row reaches it at a tick edge T, commit follows at T+DEB*SCAN_DIV.
   task automatic press_key(input logic [3:0] k, input bit io_same);
      wait_row(k[3:2], 1'b0, "row_leave");
      pressed[k] = 1'b1;
      exp_num = {exp_num[27:0], k};
      if (io_same) begin
         exp_vld = 1'b1;
         exp_ovr = 1'b0;
      end else begin
         exp_ovr = exp_ovr | exp_vld;
         exp_vld = 1'b1;
      end
      q.push_back('{k, exp_num, exp_vld, exp_ovr});
      wait_row(k[3:2], 1'b1, "row_reach");
      if (io_same) begin
         repeat (DEB*SCAN_DIV - 1) @(posedge clock);
         #1 io_read = 1'b1;
         @(posedge clock);
         #1 io_read = 1'b0;
      end
      for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge clock);
      if (q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL commit_timeout: got %0d pending, want 0", q.size());
         q.delete();
      end
   endtask

   task automatic release_keys();
      pressed = '0;
      repeat ((DEB + 3) * SCAN_DIV) @(posedge clock);
      #1;
   endtask

   task automatic io_pulse();
      @(posedge clock);
      #1 io_read = 1'b1;
      @(posedge clock);
      #1 io_read = 1'b0;
      exp_vld = 1'b0;
      exp_ovr = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_row"}, {28'd0, row}, 32'hE);
      check({tag, "_code"}, {28'd0, key_code}, 32'd0);
      check({tag, "_valid"}, {31'd0, key_valid}, 32'd0);
      check({tag, "_overrun"}, {31'd0, key_overrun}, 32'd0);
      check({tag, "_num"}, out_num, 32'd0);
   endtask

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "watchdog");
   end

   logic [3:0] keys3 [9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA};

   initial begin
      repeat (3) @(posedge clock);
      #1;
      check_reset_vals("reset");
      rst = 1'b1;

      // 1: row2/col1 -> code 9
      press_key(4'h9, 1'b0);
      check("t1_code", {28'd0, key_code}, 32'h9);
      check("t1_num", out_num, 32'h0000_0009);
      check("t1_valid", {31'd0, key_valid}, 32'd1);
      io_pulse();
      @(negedge clock);
      check("t1_valid_after_read", {31'd0, key_valid}, 32'd0);
      release_keys();

      // 2: bounce, one low tick twice -> no commit, row keeps moving 2->3->0
      for (int b = 0; b < 2; b++) begin
         wait_row(2'd2, 1'b0, "t2_leave");
         pressed[9] = 1'b1;
         wait_row(2'd2, 1'b1, "t2_reach");
         repeat (SCAN_DIV) @(posedge clock);
         #1 pressed[9] = 1'b0;
      end
      repeat (SCAN_DIV) @(posedge clock);
      @(negedge clock);
      check("t2_row3", {28'd0, row}, 32'h7);
      repeat (SCAN_DIV) @(posedge clock);
      @(negedge clock);
      check("t2_row0", {28'd0, row}, 32'hE);
      check("t2_num", out_num, 32'h0000_0009);
      check("t2_valid", {31'd0, key_valid}, 32'd0);

      // 3: nine presses
      foreach (keys3[i]) begin
         press_key(keys3[i], 1'b0);
         release_keys();
      end
      check("t3_num", out_num, 32'h2345_678A);

      // clear: number and valid drop, key_code stays
      @(posedge clock);
      #1 clr = 1'b1;
      @(posedge clock);
      #1 clr = 1'b0;
      exp_num = '0;
      exp_vld = 1'b0;
      check("clr_num", out_num, 32'd0);
      check("clr_valid", {31'd0, key_valid}, 32'd0);
      check("clr_code", {28'd0, key_code}, 32'hA);
      io_pulse();

      // 4: long hold with a 2-tick release glitch, then a fresh press
      press_key(4'h6, 1'b0);
      repeat (20 * SCAN_DIV) @(posedge clock);
      #1 pressed[6] = 1'b0;
      repeat (2 * SCAN_DIV) @(posedge clock);
      #1 pressed[6] = 1'b1;
      repeat (30 * SCAN_DIV) @(posedge clock);
      @(negedge clock);
      check("t4_hold_num", out_num, 32'h0000_0006);
      release_keys();
      press_key(4'h6, 1'b0);
      check("t4_num", out_num, 32'h0000_0066);
      release_keys();

      // 5: overrun, then IORead coinciding with a commit
      io_pulse();
      press_key(4'h1, 1'b0);
      release_keys();
      press_key(4'h2, 1'b0);
      check("t5_overrun", {31'd0, key_overrun}, 32'd1);
      release_keys();
      press_key(4'h3, 1'b1);
      check("t5_same_valid", {31'd0, key_valid}, 32'd1);
      check("t5_same_overrun", {31'd0, key_overrun}, 32'd0);
      check("t5_num", out_num, 32'h0006_6123);
      release_keys();

      // 6: two columns in one row ignored; reset mid-debounce
      pressed[4] = 1'b1;
      pressed[5] = 1'b1;
      repeat (12 * SCAN_DIV) @(posedge clock);
      wait_row(2'd1, 1'b1, "t6_multi_reach");
      wait_row(2'd2, 1'b1, "t6_multi_pass");
      check("t6_multi_num", out_num, 32'h0006_6123);
      release_keys();
      wait_row(2'd3, 1'b0, "t6_leave");
      pressed[13] = 1'b1;
      wait_row(2'd3, 1'b1, "t6_reach");
      repeat (SCAN_DIV + 2) @(posedge clock);
      #1 rst = 1'b0;
      #1 check_reset_vals("t6_rst");
      pressed = '0;
      exp_num = '0;
      exp_vld = 1'b0;
      exp_ovr = 1'b0;
      repeat (2) @(posedge clock);
      #1 rst = 1'b1;
      repeat (10 * SCAN_DIV) @(posedge clock);
      @(negedge clock);
      check("t6_post_num", out_num, 32'd0);
      check("t6_post_code", {28'd0, key_code}, 32'd0);

      check("sb_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
